// File: rtl/rom_loader.sv
// Frame-based ROM writer: A5, CNT_H, CNT_L, N big-endian words, XOR checksum; holds CPU until a good frame lands.
// Latency: rom_we one cycle after each low byte; done/err/cpu_hold update on the edge accepting CNT_L or CHK.
// Backpressure: byte_ready drops only for the single WRITE cycle of each word; all other states take a byte per cycle.
module rom_loader #(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          rom_we,
  output logic [AW-1:0] rom_addr,
  output logic [DW-1:0] rom_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam logic [7:0]  HDR       = 8'hA5;
  // Largest legal word count; 17 bits so 2**AW itself is representable for AW up to 16.
  localparam logic [16:0] MAX_WORDS = 17'(1) << AW;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CNT_H,
    S_CNT_L,
    S_DATA_H,
    S_DATA_L,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [7:0]  cnt_hi;
  logic [7:0]  hi_byte;
  logic [7:0]  csum;
  logic [15:0] words_left;
  logic [15:0] n_words;
  logic        xfer;

  assign xfer    = byte_valid && byte_ready;
  assign n_words = {cnt_hi, byte_data};

  // Frame parser, word assembler and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt_hi     <= 8'h00;
      hi_byte    <= 8'h00;
      csum       <= 8'h00;
      words_left <= 16'h0000;
      byte_ready <= 1'b1;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_data   <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          // Only a header restarts a load; anything else is swallowed.
          if (xfer && byte_data == HDR) begin
            state    <= S_CNT_H;
            csum     <= 8'h00;
            rom_addr <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        S_CNT_H: begin
          if (xfer) begin
            cnt_hi <= byte_data;
            csum   <= csum ^ byte_data;
            state  <= S_CNT_L;
          end
        end
        S_CNT_L: begin
          if (xfer) begin
            csum <= csum ^ byte_data;
            if (n_words == 16'h0000 || {1'b0, n_words} > MAX_WORDS) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              words_left <= n_words;
              state      <= S_DATA_H;
            end
          end
        end
        S_DATA_H: begin
          if (xfer) begin
            hi_byte <= byte_data;
            csum    <= csum ^ byte_data;
            state   <= S_DATA_L;
          end
        end
        S_DATA_L: begin
          if (xfer) begin
            rom_data   <= {hi_byte, byte_data};
            csum       <= csum ^ byte_data;
            rom_we     <= 1'b1;
            byte_ready <= 1'b0;
            state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          rom_we     <= 1'b0;
          byte_ready <= 1'b1;
          words_left <= words_left - 16'd1;
          // Address advances only when another word follows, so a full 2**AW frame never wraps to 0.
          if (words_left == 16'd1) begin
            state <= S_CHK;
          end else begin
            rom_addr <= rom_addr + {{(AW-1){1'b0}}, 1'b1};
            state    <= S_DATA_H;
          end
        end
        S_CHK: begin
          if (xfer) begin
            if (byte_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          rom_we     <= 1'b0;
          byte_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: expected ROM writes go to a queue, a negedge monitor pops them on rom_we.
// Status outputs are compared one cycle after the deciding byte is accepted.
// The DUT is built with AW=12 so the full-size boundary frame stays within a small cycle budget.
module tb_rom_loader;

  localparam int TB_AW = 12;

  logic             clk;
  logic             reset;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             rom_we;
  logic [TB_AW-1:0] rom_addr;
  logic [15:0]      rom_data;
  logic             cpu_hold;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  rom_loader #(.AW(TB_AW), .DW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .rom_we     (rom_we),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Write monitor: every rom_we cycle must match the next expected (addr, data).
  always @(negedge clk) begin
    if (reset && rom_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rom_write unexpected: got addr=%h data=%h, required no write", rom_addr, rom_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({16'(rom_addr), rom_data} !== e)
          begin
            errors++;
            $display("FAIL rom_write: got addr=%h data=%h, required addr=%h data=%h",
                     rom_addr, rom_data, e[31:16], e[15:0]);
          end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Present one byte and hold it until it transfers; returns the number of not-ready cycles seen.
  task automatic send_byte(input logic [7:0] b, output int waits);
    logic rdy;
    waits      = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (1) begin
      rdy = byte_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 8) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: byte %h not accepted within 8 cycles", b);
        break;
      end
    end
  endtask

  task automatic sb(input logic [7:0] b);
    int w;
    send_byte(b, w);
  endtask

  task automatic expect_write(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  // Two-word frame 12 34 / AB CD; the correct checksum is 0x42.
  task automatic nominal(input logic [7:0] chk_byte);
    int w;
    expect_write(16'h0000, 16'h1234);
    expect_write(16'h0001, 16'hABCD);
    sb(8'hA5);
    chk("hdr_hold", {31'b0, cpu_hold}, 32'd1);
    chk("hdr_flags", {30'b0, done, err}, 32'd0);
    sb(8'h00);
    sb(8'h02);
    sb(8'h12);
    sb(8'h34);
    chk("write_ready_low", {31'b0, byte_ready}, 32'd0);
    send_byte(8'hAB, w);
    chk("stall_cycles", w, 32'd1);
    sb(8'hCD);
    send_byte(chk_byte, w);
    chk("chk_stall_cycles", w, 32'd1);
    byte_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] wd;
    logic [7:0]  cs;
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, byte_ready}, 32'd1);
    chk("rst_we", {31'b0, rom_we}, 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_data", 32'(rom_data), 32'd0);
    chk("rst_hold", {31'b0, cpu_hold}, 32'd1);
    chk("rst_flags", {30'b0, done, err}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Garbage in IDLE, then a good frame.
    sb(8'h00);
    sb(8'hFF);
    sb(8'h5A);
    byte_valid = 1'b0;
    chk("garbage_hold", {31'b0, cpu_hold}, 32'd1);
    chk("garbage_done", {31'b0, done}, 32'd0);
    nominal(8'h42);
    chk("nom_done", {31'b0, done}, 32'd1);
    chk("nom_hold", {31'b0, cpu_hold}, 32'd0);
    chk("nom_err", {31'b0, err}, 32'd0);

    // Reload after DONE: checksum 00^01^BE^EF = 0x50.
    @(posedge clk);
    #1;
    expect_write(16'h0000, 16'hBEEF);
    sb(8'hA5);
    chk("reload_hold", {31'b0, cpu_hold}, 32'd1);
    chk("reload_done", {31'b0, done}, 32'd0);
    sb(8'h00);
    sb(8'h01);
    sb(8'hBE);
    sb(8'hEF);
    sb(8'h50);
    byte_valid = 1'b0;
    chk("reload_end_done", {31'b0, done}, 32'd1);
    chk("reload_end_hold", {31'b0, cpu_hold}, 32'd0);

    // Bad checksum, then recovery with a good frame.
    nominal(8'h43);
    chk("bad_err", {31'b0, err}, 32'd1);
    chk("bad_done", {31'b0, done}, 32'd0);
    chk("bad_hold", {31'b0, cpu_hold}, 32'd1);
    nominal(8'h42);
    chk("recover_done", {31'b0, done}, 32'd1);
    chk("recover_err", {31'b0, err}, 32'd0);

    // Count bounds: zero, one past 2**AW, and far too large.
    sb(8'hA5); sb(8'h00); sb(8'h00);
    byte_valid = 1'b0;
    chk("n0_err", {31'b0, err}, 32'd1);
    chk("n0_hold", {31'b0, cpu_hold}, 32'd1);
    sb(8'hA5);
    chk("n_restart_err", {31'b0, err}, 32'd0);
    sb(8'h10); sb(8'h01);
    byte_valid = 1'b0;
    chk("n_max_plus1_err", {31'b0, err}, 32'd1);
    sb(8'hA5); sb(8'h80); sb(8'h01);
    byte_valid = 1'b0;
    chk("n8001_err", {31'b0, err}, 32'd1);

    // Full-size frame of 2**AW words with a bench-computed checksum.
    sb(8'hA5); sb(8'h10); sb(8'h00);
    cs = 8'h10;
    for (int i = 0; i < (1 << TB_AW); i++) begin
      wd = 16'(i * 16'h0107) ^ 16'h3C96;
      expect_write(16'(i), wd);
      sb(wd[15:8]);
      sb(wd[7:0]);
      cs = cs ^ wd[15:8] ^ wd[7:0];
    end
    sb(cs);
    byte_valid = 1'b0;
    chk("full_done", {31'b0, done}, 32'd1);
    chk("full_last_addr", 32'(rom_addr), 32'h0FFF);
    chk("full_hold", {31'b0, cpu_hold}, 32'd0);

    // Reset after A5 00 02 12.
    @(posedge clk);
    #1;
    sb(8'hA5); sb(8'h00); sb(8'h02); sb(8'h12);
    byte_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_we", {31'b0, rom_we}, 32'd0);
    chk("midrst_addr", 32'(rom_addr), 32'd0);
    chk("midrst_hold", {31'b0, cpu_hold}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset during the second WRITE: the pending write is dropped.
    expect_write(16'h0000, 16'h1234);
    sb(8'hA5); sb(8'h00); sb(8'h02); sb(8'h12); sb(8'h34); sb(8'hAB); sb(8'hCD);
    byte_valid = 1'b0;
    chk("wrst_pre_we", {31'b0, rom_we}, 32'd1);
    chk("wrst_pre_addr", 32'(rom_addr), 32'd1);
    reset = 1'b0;
    #1;
    chk("wrst_we", {31'b0, rom_we}, 32'd0);
    chk("wrst_addr", 32'(rom_addr), 32'd0);
    chk("wrst_ready", {31'b0, byte_ready}, 32'd1);
    chk("wrst_hold", {31'b0, cpu_hold}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Back in IDLE: data-like bytes are discarded, then a good frame completes.
    sb(8'h12); sb(8'h34); sb(8'h42);
    byte_valid = 1'b0;
    chk("post_rst_done", {31'b0, done}, 32'd0);
    nominal(8'h42);
    chk("post_rst_final_done", {31'b0, done}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("writes_outstanding", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
